hub75_fb_write_arbiter: RTL
===========================

Name: hub75_fb_write_arbiter

Overview:
Shares the single framebuffer write port (addr/data/en) between two pixel-writing requesters: a host loader and a pattern generator. It also contains a built-in clear engine that fills the whole frame with one colour. The block sits between the pixel sources and the driver top-level write inputs. Its outputs are registered and connect directly to the framebuffer write interface.

Parameters:
hpixel_p, 64, display width in pixels
vpixel_p, 64, display height in pixels
bpp_p, 8, bits per colour channel
frame_size_p (localparam), hpixel_p*vpixel_p, number of pixel locations
addr_width_p (localparam), $clog2(frame_size_p), framebuffer address width

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
i_req0_valid  in  1  host write request
i_req0_addr  in  addr_width_p  host pixel address
i_req0_data  in  3*bpp_p  host pixel {R,G,B}
o_req0_ready  out  1  host request accepted this cycle
i_req1_valid  in  1  generator write request
i_req1_addr  in  addr_width_p  generator pixel address
i_req1_data  in  3*bpp_p  generator pixel {R,G,B}
o_req1_ready  out  1  generator request accepted this cycle
i_clear_start  in  1  start a full-frame clear (level sampled)
i_clear_color  in  3*bpp_p  fill colour, captured at start
o_clear_busy  out  1  clear in progress
o_clear_done  out  1  one-cycle pulse when clear completes
o_oob  out  1  one-cycle pulse: accepted request had addr >= frame_size_p
o_wr_addr  out  addr_width_p  framebuffer write address (registered)
o_wr_data  out  3*bpp_p  framebuffer write data (registered)
o_wr_en  out  1  framebuffer write enable (registered)

Behaviour:
- States: ARB and CLEAR. Reset → ARB. All registered outputs reset to 0. The round-robin pointer resets to favour req0.
- Readys are combinational. In ARB with i_clear_start=0:
  - Only one valid → that requester's ready=1.
  - Both valid → the pointer's favoured requester gets ready.
  - Readys are never both 1.
  - Readys are 0 in CLEAR, 0 while i_clear_start=1, and 0 during rst.
- Transfer = valid && ready. Requesters hold addr/data stable until the transfer.
- After a transfer, the pointer favours the other requester. With no transfer, the pointer holds.
- Write latency is 1 cycle. On the edge ending a transfer cycle, o_wr_addr/o_wr_data load the granted request and o_wr_en=1. With no transfer, o_wr_en=0 and addr/data hold their values.
- Out-of-range requests (addr >= frame_size_p, possible only for non-power-of-2 frames):
  - Still accepted.
  - o_wr_en stays 0; o_oob pulses on the same edge the write would have appeared.
  - The pointer still advances.
- Clear start: i_clear_start=1 in ARB at edge E0 has priority over requests. At E0:
  - i_clear_color is captured.
  - Counter = 0, state → CLEAR, o_clear_busy=1.
- Clear sequence: at each edge E1..EN (N=frame_size_p), o_wr_en=1, o_wr_addr=counter, o_wr_data=captured colour, counter+1. Addresses therefore run 0..N-1 ascending, one per cycle, with no gaps.
- Clear end: at EN, state → ARB, o_clear_busy=0, o_clear_done=1 for one cycle. The counter wraps to 0.
  - o_clear_busy is high for exactly N cycles.
  - The first request transfer can occur in the cycle after EN. Its write appears at EN+1, so there is no port collision.
- i_clear_start while in CLEAR is ignored; there is no queuing. A clear held high re-triggers on the first ARB cycle after completion.
- Reset mid-clear aborts immediately: no o_clear_done pulse, o_wr_en=0 on the next cycle, state ARB.
- No combinational path from any input to o_wr_*.

Test Plan:
- Reset then idle: all outputs 0 and both readys 0 for 10 cycles with no valids.
- Single requester: req0 valid with addr=0x123, data=0xFF00AA for 1 cycle → ready0=1 that cycle, and the next cycle shows o_wr_en=1, addr=0x123, data=0xFF00AA; req1 idle, ready1=0.
- Contention: both valid continuously for 6 cycles with distinct data → grants alternate 0,1,0,1,0,1 starting with req0 after reset, o_wr_en high 6 consecutive cycles, writes in grant order.
- Clear: pulse start with colour 0x0000FF (64x64) → busy high exactly 4096 cycles, writes to addresses 0..4095 all with 0x0000FF, done pulses once coincident with address 4095, readys 0 throughout despite both valids high.
- Start vs. request in the same cycle: req1 valid and start high in one cycle → ready1=0, the clear wins, and req1 is accepted the first cycle after done with its write one cycle later.
- Reset mid-clear: assert rst at clear address 1000 → o_wr_en=0 next cycle, no done pulse; a new start afterwards begins again at address 0.

Source files
------------

// File: rtl/hub75_fb_write_arbiter.sv
// Framebuffer write-port arbiter: round-robin between host and pattern generator,
// plus a full-frame clear engine. All framebuffer-side outputs are registered.
module hub75_fb_write_arbiter #(
    parameter  int hpixel_p     = 64,
    parameter  int vpixel_p     = 64,
    parameter  int bpp_p        = 8,
    localparam int frame_size_p = hpixel_p * vpixel_p,
    localparam int addr_width_p = $clog2(frame_size_p)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req0_valid,
    input  logic [addr_width_p-1:0] i_req0_addr,
    input  logic [3*bpp_p-1:0]      i_req0_data,
    output logic                    o_req0_ready,
    input  logic                    i_req1_valid,
    input  logic [addr_width_p-1:0] i_req1_addr,
    input  logic [3*bpp_p-1:0]      i_req1_data,
    output logic                    o_req1_ready,
    input  logic                    i_clear_start,
    input  logic [3*bpp_p-1:0]      i_clear_color,
    output logic                    o_clear_busy,
    output logic                    o_clear_done,
    output logic                    o_oob,
    output logic [addr_width_p-1:0] o_wr_addr,
    output logic [3*bpp_p-1:0]      o_wr_data,
    output logic                    o_wr_en
);

    localparam logic [addr_width_p:0]   FRAME_LIM = (addr_width_p + 1)'(frame_size_p);
    localparam logic [addr_width_p-1:0] LAST_ADDR = addr_width_p'(frame_size_p - 1);

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  state_q;
    logic                    fav1_q;
    logic [addr_width_p-1:0] clr_cnt_q;
    logic [3*bpp_p-1:0]      clr_color_q;
    logic [addr_width_p-1:0] wr_addr_q;
    logic [3*bpp_p-1:0]      wr_data_q;
    logic                    wr_en_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    oob_q;

    logic                    arb_open_d;
    logic                    grant0_d;
    logic                    grant1_d;
    logic [addr_width_p-1:0] xfer_addr_d;
    logic [3*bpp_p-1:0]      xfer_data_d;
    logic                    xfer_oob_d;

    // A pending clear start blocks grants so the clear wins a same-cycle race.
    always_comb begin
        arb_open_d  = (state_q == ARB) && !i_clear_start && !rst;
        grant0_d    = arb_open_d && i_req0_valid && (!i_req1_valid || !fav1_q);
        grant1_d    = arb_open_d && i_req1_valid && (!i_req0_valid || fav1_q);
        xfer_addr_d = grant1_d ? i_req1_addr : i_req0_addr;
        xfer_data_d = grant1_d ? i_req1_data : i_req0_data;
        xfer_oob_d  = ({1'b0, xfer_addr_d} >= FRAME_LIM);
    end

    assign o_req0_ready = grant0_d;
    assign o_req1_ready = grant1_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB;
            fav1_q    <= 1'b0;
            clr_cnt_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            oob_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            oob_q   <= 1'b0;
            case (state_q)
                ARB: begin
                    if (i_clear_start) begin
                        state_q   <= CLEAR;
                        clr_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end else if (grant0_d || grant1_d) begin
                        wr_addr_q <= xfer_addr_d;
                        wr_data_q <= xfer_data_d;
                        wr_en_q   <= !xfer_oob_d;
                        oob_q     <= xfer_oob_d;
                        fav1_q    <= grant0_d;
                    end
                end
                CLEAR: begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= clr_cnt_q;
                    wr_data_q <= clr_color_q;
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_q   <= ARB;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        clr_cnt_q <= '0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + addr_width_p'(1);
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    // Fill colour is pure data; it only needs loading when a clear actually starts.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == ARB) && i_clear_start) begin
            clr_color_q <= i_clear_color;
        end
    end

    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;
    assign o_wr_en      = wr_en_q;
    assign o_clear_busy = busy_q;
    assign o_clear_done = done_q;
    assign o_oob        = oob_q;

endmodule
